// File: rtl/ascon_hash_stream_if.sv
// Message-in and digest-out stream bundle for ascon_hash_stream.
// The host side uses master; the hash core uses slave. R must match the core's R.
interface ascon_hash_stream_if #(
  parameter int R = 64
);
  localparam int BW = $clog2(R / 8) + 1;

  logic [R-1:0]  msg_data;
  logic          msg_valid;
  logic          msg_last;
  logic [BW-1:0] msg_bytes;
  logic          msg_ready;
  logic [R-1:0]  out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  modport master (
    output msg_data, msg_valid, msg_last, msg_bytes, out_ready,
    input  msg_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  msg_data, msg_valid, msg_last, msg_bytes, out_ready,
    output msg_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/ascon_hash_stream.sv
// Streaming Ascon Hash / XOF: absorbs R-bit message blocks with hardware padding
// and squeezes R-bit output blocks, one permutation round per clock.
module ascon_hash_stream #(
  parameter int R     = 64,
  parameter int A     = 12,
  parameter int B     = 12,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [OUT_W-1:0] out_blocks,
  input  logic             abort,
  output logic             busy,
  ascon_hash_stream_if.slave bus
);
  localparam int RB = R / 8;
  localparam logic [OUT_W-1:0] HASH_BLKS = OUT_W'((256 + R - 1) / R);
  localparam logic [3:0] A4 = 4'(A);
  localparam logic [3:0] B4 = 4'(B);
  localparam logic [63:0] IV_BASE = (64'(R) << 48) | (64'(A) << 40) | (64'(A - B) << 12);
  localparam logic [319:0] PAD_BIT = {1'b1, 319'd0};

  typedef enum logic [2:0] {IDLE, INIT, ABSORB, ABS_PERM, PAD, FINAL, OUT, SQ_PERM} state_t;

  state_t           state;
  logic [319:0]     s;
  logic [319:0]     perm_s;
  logic [319:0]     s_abs;
  logic [319:0]     round_out;
  logic [3:0]       rcnt;
  logic [3:0]       cur_rounds;
  logic [3:0]       ridx;
  logic [R-1:0]     mblk;
  logic             last_full;
  logic [63:0]      iv;
  logic [OUT_W-1:0] remaining;
  logic [OUT_W-1:0] start_blocks;
  int               nbytes;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] ascon_round(input logic [319:0] st, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = st[319:256];
    x1 = st[255:192];
    x2 = st[191:128] ^ {56'd0, c};
    x3 = st[127:64];
    x4 = st[63:0];
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  // Oversized byte counts clamp to a full block; non-last blocks are always full.
  always_comb begin
    nbytes = int'(bus.msg_bytes);
    if (nbytes > RB || !bus.msg_last) nbytes = RB;
    mblk = '0;
    for (int i = 0; i < RB; i++) begin
      if (i < nbytes) mblk[R-1-8*i -: 8] = bus.msg_data[R-1-8*i -: 8];
      else if (i == nbytes) mblk[R-1-8*i] = 1'b1;
    end
    last_full = bus.msg_last && (nbytes == RB);
    s_abs = {s[319 -: R] ^ mblk, s[319-R:0]};
  end

  // Round constants assume rounds <= 12: a p^n run uses indices 12-n .. 11.
  always_comb begin
    cur_rounds = (state == INIT || state == FINAL) ? A4 : B4;
    ridx = (4'd12 - cur_rounds) + rcnt;
    round_out = ascon_round(perm_s, {~ridx, ridx});
    iv = IV_BASE | (mode ? 64'd0 : 64'd256);
    if (!mode) start_blocks = HASH_BLKS;
    else if (out_blocks == '0) start_blocks = OUT_W'(1);
    else start_blocks = out_blocks;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s             <= '0;
      perm_s        <= '0;
      rcnt          <= '0;
      remaining     <= '0;
      busy          <= 1'b0;
      bus.msg_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else if (abort) begin
      state         <= IDLE;
      busy          <= 1'b0;
      bus.msg_ready <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s         <= {iv, 256'd0};
            perm_s    <= {iv, 256'd0};
            rcnt      <= '0;
            remaining <= start_blocks;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end
        INIT, ABS_PERM, PAD, FINAL, SQ_PERM: begin
          // The working copy runs the rounds; s only changes when the run completes.
          if (rcnt != cur_rounds) begin
            perm_s <= round_out;
            rcnt   <= rcnt + 4'd1;
          end else begin
            rcnt <= '0;
            case (state)
              INIT, ABS_PERM: begin
                s             <= perm_s;
                bus.msg_ready <= 1'b1;
                state         <= ABSORB;
              end
              PAD: begin
                s      <= perm_s ^ PAD_BIT;
                perm_s <= perm_s ^ PAD_BIT;
                state  <= FINAL;
              end
              default: begin
                s             <= perm_s;
                bus.out_valid <= 1'b1;
                bus.out_data  <= perm_s[319 -: R];
                bus.out_last  <= (remaining == OUT_W'(1));
                state         <= OUT;
              end
            endcase
          end
        end
        ABSORB: begin
          if (bus.msg_valid && bus.msg_ready) begin
            s             <= s_abs;
            perm_s        <= s_abs;
            rcnt          <= '0;
            bus.msg_ready <= 1'b0;
            if (!bus.msg_last) state <= ABS_PERM;
            else if (last_full) state <= PAD;
            else state <= FINAL;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            remaining     <= remaining - OUT_W'(1);
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            if (bus.out_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              perm_s <= s;
              rcnt   <= '0;
              state  <= SQ_PERM;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ascon_hash_stream.sv
// Scoreboard bench for ascon_hash_stream (R=64): a reference Ascon sponge model
// queues expected output blocks, a negedge monitor pops and compares them.
module tb_ascon_hash_stream;
  typedef byte unsigned bq_t[$];
  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic [7:0] out_blocks;
  logic       abort;
  logic       busy;
  bit         bp_mode;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks;
  int          n_pass;
  int          n_fail;
  int          hs_count;
  bit          stalled;
  logic [63:0] held;

  ascon_hash_stream_if #(.R(64)) bus();

  ascon_hash_stream #(.R(64), .A(12), .B(12), .OUT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .out_blocks (out_blocks),
    .abort      (abort),
    .busy       (busy),
    .bus        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no end of run, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] model_p(input logic [319:0] st, input int rounds);
    logic [63:0] x[5];
    logic [63:0] t[5];
    for (int i = 0; i < 5; i++) x[i] = st[319-64*i -: 64];
    for (int r = 12 - rounds; r < 12; r++) begin
      x[2] ^= 64'(((15 - r) << 4) | r);
      x[0] ^= x[4];
      x[4] ^= x[3];
      x[2] ^= x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i + 1) % 5];
      for (int i = 0; i < 5; i++) x[i] ^= t[(i + 1) % 5];
      x[1] ^= x[0];
      x[0] ^= x[4];
      x[3] ^= x[2];
      x[2] = ~x[2];
      x[0] ^= rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] ^= rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] ^= rotr(x[2], 1) ^ rotr(x[2], 6);
      x[3] ^= rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] ^= rotr(x[4], 7) ^ rotr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  // Textbook sponge: pad with 0x80 then zeros to a multiple of 8 bytes.
  task automatic push_model(input bq_t msg, input bit xof, input int nout);
    logic [319:0] st;
    logic [63:0]  w;
    exp_t         e;
    bq_t          m;
    st = {(xof ? 64'h00400C0000000000 : 64'h00400C0000000100), 256'd0};
    st = model_p(st, 12);
    m = msg;
    m.push_back(8'h80);
    while (m.size() % 8 != 0) m.push_back(8'h00);
    for (int k = 0; k < m.size() / 8; k++) begin
      w = '0;
      for (int b = 0; b < 8; b++) w = {w[55:0], m[8*k+b]};
      st[319:256] = st[319:256] ^ w;
      st = model_p(st, 12);
    end
    for (int o = 0; o < nout; o++) begin
      e.data = st[319:256];
      e.last = (o == nout - 1);
      exp_q.push_back(e);
      if (o != nout - 1) st = model_p(st, 12);
    end
  endtask

  task automatic push_known();
    logic [63:0] kv[4];
    exp_t        e;
    kv[0] = 64'h7346BC14F036E87A;
    kv[1] = 64'hE03D0997913088F5;
    kv[2] = 64'hF68411434B3CF8B5;
    kv[3] = 64'h4FA796A80D251F91;
    for (int i = 0; i < 4; i++) begin
      e.data = kv[i];
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endtask

  function automatic bq_t rand_msg(input int n);
    bq_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic do_start(input bit xof, input int oblk);
    start = 1'b1;
    mode = xof;
    out_blocks = 8'(oblk);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Unused tail bytes carry random garbage so masking is exercised.
  task automatic send_block(input bq_t msg, input int k, input bit last, input bit gaps);
    int          nb;
    int          t;
    logic [63:0] d;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    nb = msg.size() - 8 * k;
    if (nb > 8) nb = 8;
    if (nb < 0) nb = 0;
    for (int b = 0; b < 8; b++) begin
      if (b < nb) d[63-8*b -: 8] = msg[8*k+b];
      else d[63-8*b -: 8] = 8'($urandom);
    end
    bus.msg_data = d;
    bus.msg_bytes = 4'(nb);
    bus.msg_last = last;
    bus.msg_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.msg_ready && t < 1000);
    check("msg_accept", bus.msg_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.msg_valid = 1'b0;
  endtask

  task automatic run_job(input bq_t msg, input bit xof, input int oblk, input bit gaps,
                         input bit poke, input bit known, output int lat);
    int nout;
    int nin;
    int t;
    nout = xof ? ((oblk == 0) ? 1 : oblk) : 4;
    if (known) push_known();
    else push_model(msg, xof, nout);
    hs_count = 0;
    do_start(xof, oblk);
    nin = (msg.size() == 0) ? 1 : (msg.size() + 7) / 8;
    for (int k = 0; k < nin; k++) begin
      send_block(msg, k, k == nin - 1, gaps);
      if (poke && k == 0) begin
        start = 1'b1;
        mode = ~xof;
        out_blocks = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode = xof;
      end
    end
    lat = 0;
    while (!bus.out_valid && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
    end
    t = 0;
    while ((busy || exp_q.size() != 0) && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("job_busy_clear", busy, 1'b0);
    check("job_drained", exp_q.size(), 0);
    check("job_out_count", hs_count, nout);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = bp_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // Compare on the negedge before the edge where the handshake happens.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (stalled) check("stall_hold", bus.out_data, held);
      if (bus.out_ready) begin
        hs_count++;
        check("sb_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_data", bus.out_data, mon_e.data);
          check("out_last", bus.out_last, mon_e.last);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = bus.out_data;
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    bq_t msg;
    int  lat8;
    int  lat9;
    int  lat_x;
    int  t;
    n_checks = 0;
    n_pass = 0;
    n_fail = 0;
    hs_count = 0;
    stalled = 1'b0;
    held = '0;
    bp_mode = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    mode = 1'b0;
    out_blocks = '0;
    abort = 1'b0;
    bus.msg_valid = 1'b0;
    bus.msg_data = '0;
    bus.msg_last = 1'b0;
    bus.msg_bytes = '0;

    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_msg_ready", bus.msg_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_out_data", bus.out_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] hash of empty message against known digest");
    msg = {};
    run_job(msg, 1'b0, 0, 1'b0, 1'b0, 1'b1, lat_x);

    $display("[TB] hash of 9-byte and 8-byte messages");
    run_job(rand_msg(9), 1'b0, 0, 1'b0, 1'b0, 1'b0, lat9);
    run_job(rand_msg(8), 1'b0, 0, 1'b0, 1'b0, 1'b0, lat8);
    check("pad_path_extra_cycles", lat8 - lat9, 13);

    $display("[TB] XOF 5 blocks with start pulsed while busy");
    run_job(rand_msg(24), 1'b1, 5, 1'b0, 1'b1, 1'b0, lat_x);
    $display("[TB] XOF with out_blocks=0");
    run_job(rand_msg(5), 1'b1, 0, 1'b0, 1'b0, 1'b0, lat_x);

    $display("[TB] backpressure and message gaps");
    bp_mode = 1'b1;
    run_job(rand_msg(13), 1'b1, 7, 1'b1, 1'b0, 1'b0, lat_x);
    run_job(rand_msg(20), 1'b0, 0, 1'b1, 1'b0, 1'b0, lat_x);
    bp_mode = 1'b0;

    $display("[TB] XOF maximum length");
    msg = {};
    run_job(msg, 1'b1, 255, 1'b0, 1'b0, 1'b0, lat_x);

    $display("[TB] abort during absorb permutation");
    msg = rand_msg(16);
    do_start(1'b0, 0);
    send_block(msg, 0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_msg_ready", bus.msg_ready, 1'b0);
    check("abort_out_valid", bus.out_valid, 1'b0);
    run_job(rand_msg(3), 1'b0, 0, 1'b0, 1'b0, 1'b0, lat_x);

    $display("[TB] async reset during squeeze permutation");
    msg = {};
    push_model(msg, 1'b1, 6);
    hs_count = 0;
    do_start(1'b1, 6);
    send_block(msg, 0, 1'b1, 1'b0);
    t = 0;
    while (hs_count < 1 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("sq_first_block_seen", hs_count, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_msg_ready", bus.msg_ready, 1'b0);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_last", bus.out_last, 1'b0);
    check("arst_out_data", bus.out_data, 64'd0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
